// File: rtl/jtag_tap_dtm_pkg.sv
// Shared definitions for the JTAG debug transport module: TAP states, IR codes,
// DMI op/status codes, DTMCS bit positions and DR lengths.
package jtag_defs;

  typedef enum logic [3:0] {
    TAP_RESET    = 4'h0,
    TAP_IDLE     = 4'h1,
    TAP_SEL_DR   = 4'h2,
    TAP_CAP_DR   = 4'h3,
    TAP_SHIFT_DR = 4'h4,
    TAP_EXIT1_DR = 4'h5,
    TAP_PAUSE_DR = 4'h6,
    TAP_EXIT2_DR = 4'h7,
    TAP_UPD_DR   = 4'h8,
    TAP_SEL_IR   = 4'h9,
    TAP_CAP_IR   = 4'hA,
    TAP_SHIFT_IR = 4'hB,
    TAP_EXIT1_IR = 4'hC,
    TAP_PAUSE_IR = 4'hD,
    TAP_EXIT2_IR = 4'hE,
    TAP_UPD_IR   = 4'hF
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [4:0] IR_BYPASS = 5'h1f;

  localparam logic [1:0] DMI_OP_NOP   = 2'b00;
  localparam logic [1:0] DMI_OP_READ  = 2'b01;
  localparam logic [1:0] DMI_OP_WRITE = 2'b10;

  localparam logic [1:0] DMI_STAT_OK   = 2'b00;
  localparam logic [1:0] DMI_STAT_BUSY = 2'b11;

  localparam int DTMCS_DMIRESET     = 16;
  localparam int DTMCS_DMIHARDRESET = 17;

  localparam int LEN_IR     = 5;
  localparam int LEN_IDCODE = 32;
  localparam int LEN_DTMCS  = 32;
  localparam int LEN_BYPASS = 1;

  // IEEE 1149.1 TAP transition table, advanced once per TCK rise.
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    unique case (s)
      TAP_RESET:    return tms ? TAP_RESET    : TAP_IDLE;
      TAP_IDLE:     return tms ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_DR:   return tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: return tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: return tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   return tms ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_IR:   return tms ? TAP_RESET    : TAP_CAP_IR;
      TAP_CAP_IR:   return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: return tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: return tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   return tms ? TAP_SEL_DR   : TAP_IDLE;
      default:      return TAP_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Brings the asynchronous probe pins into the system clock domain and flags
// TCK edges; edges are seen two clk cycles after the pin moves.
module jtag_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tms_o,
  output logic tdi_o,
  output logic tck_rise_o,
  output logic tck_fall_o
);

  logic [1:0] tck_q, tms_q, tdi_q;
  logic       tck_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q      <= '0;
      tms_q      <= '0;
      tdi_q      <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      tck_q      <= {tck_q[0], tck_i};
      tms_q      <= {tms_q[0], tms_i};
      tdi_q      <= {tdi_q[0], tdi_i};
      tck_prev_q <= tck_q[1];
    end
  end

  assign tms_o      = tms_q[1];
  assign tdi_o      = tdi_q[1];
  assign tck_rise_o = tck_q[1] & ~tck_prev_q;
  assign tck_fall_o = ~tck_q[1] & tck_prev_q;

endmodule

// File: rtl/jtag_tap_dtm.sv
// Target-side JTAG TAP with IDCODE/DTMCS/DMI/BYPASS registers, turning DMI
// updates into single-outstanding requests toward the debug module.
module jtag_tap_dtm
  import jtag_defs::*;
#(
  parameter logic [31:0] IDCODE    = 32'h1E200A6D,
  parameter int          ABITS     = 6,
  parameter int          IDLE_HINT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jtag_TCK,
  input  logic               jtag_TMS,
  input  logic               jtag_TDI,
  output logic               jtag_TDO,
  output logic               dtm_req_valid,
  output logic [ABITS+33:0]  dtm_req_data,
  input  logic               dm_ack,
  input  logic               dm_resp_valid,
  input  logic [31:0]        dm_resp_data
);

  localparam int DL = ABITS + 34;

  logic tck_rise, tck_fall, tms_s, tdi_s;

  jtag_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .tck_i      (jtag_TCK),
    .tms_i      (jtag_TMS),
    .tdi_i      (jtag_TDI),
    .tms_o      (tms_s),
    .tdi_o      (tdi_s),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall)
  );

  tap_state_e        state_q, state_d;
  logic [4:0]        ir_q, ir_d, ir_sel;
  logic [DL-1:0]     shift_q, shift_d, req_data_q, req_data_d;
  logic              tdo_q, tdo_d, busy_q, busy_d, sticky_q, sticky_d;
  logic              req_valid_q, req_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [ABITS-1:0]  last_addr_q, last_addr_d;
  logic [1:0]        status;
  logic [31:0]       dtmcs_cap;

  assign status    = (sticky_q || busy_q) ? DMI_STAT_BUSY : DMI_STAT_OK;
  assign dtmcs_cap = {14'h0, 3'b000, 3'(IDLE_HINT), status, 6'(ABITS), 4'h1};

  always_comb begin
    case (ir_q)
      IR_IDCODE, IR_DTMCS, IR_DMI: ir_sel = ir_q;
      default:                     ir_sel = IR_BYPASS;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    shift_d     = shift_q;
    tdo_d       = tdo_q;
    busy_d      = busy_q;
    sticky_d    = sticky_q;
    req_valid_d = req_valid_q;
    req_data_d  = req_data_q;
    rsp_data_d  = rsp_data_q;
    last_addr_d = last_addr_q;

    if (req_valid_q && dm_ack) req_valid_d = 1'b0;
    if (dm_resp_valid) begin
      rsp_data_d = dm_resp_data;
      busy_d     = 1'b0;
    end

    if (tck_rise) begin
      state_d = tap_next(state_q, tms_s);
      // Capture/shift act on the state being left; TDI enters at the MSB of the active length.
      case (state_q)
        TAP_CAP_IR:   shift_d = DL'(5'b00001);
        TAP_SHIFT_IR: shift_d = {{(DL-LEN_IR){1'b0}}, tdi_s, shift_q[LEN_IR-1:1]};
        TAP_CAP_DR: begin
          case (ir_sel)
            IR_IDCODE: shift_d = DL'(IDCODE);
            IR_DTMCS:  shift_d = DL'(dtmcs_cap);
            IR_DMI:    shift_d = {last_addr_q, rsp_data_q, status};
            default:   shift_d = '0;
          endcase
        end
        TAP_SHIFT_DR: begin
          case (ir_sel)
            IR_IDCODE: shift_d = {{(DL-LEN_IDCODE){1'b0}}, tdi_s, shift_q[LEN_IDCODE-1:1]};
            IR_DTMCS:  shift_d = {{(DL-LEN_DTMCS){1'b0}}, tdi_s, shift_q[LEN_DTMCS-1:1]};
            IR_DMI:    shift_d = {tdi_s, shift_q[DL-1:1]};
            default:   shift_d = {{(DL-LEN_BYPASS){1'b0}}, tdi_s};
          endcase
        end
        default: ;
      endcase

      case (state_d)
        TAP_RESET: begin
          ir_d     = IR_IDCODE;
          sticky_d = 1'b0;
        end
        TAP_UPD_IR: ir_d = shift_q[LEN_IR-1:0];
        TAP_UPD_DR: begin
          if (ir_sel == IR_DMI &&
              (shift_q[1:0] == DMI_OP_READ || shift_q[1:0] == DMI_OP_WRITE)) begin
            if (busy_q || sticky_q) begin
              sticky_d = 1'b1;
            end else begin
              req_data_d  = shift_q;
              req_valid_d = 1'b1;
              busy_d      = 1'b1;
              last_addr_d = shift_q[DL-1:34];
            end
          end else if (ir_sel == IR_DTMCS) begin
            if (shift_q[DTMCS_DMIRESET]) sticky_d = 1'b0;
            if (shift_q[DTMCS_DMIHARDRESET]) begin
              sticky_d    = 1'b0;
              busy_d      = 1'b0;
              req_valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end

    if (tck_fall && (state_q == TAP_SHIFT_IR || state_q == TAP_SHIFT_DR)) tdo_d = shift_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TAP_RESET;
      ir_q        <= IR_IDCODE;
      shift_q     <= '0;
      tdo_q       <= 1'b0;
      busy_q      <= 1'b0;
      sticky_q    <= 1'b0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      rsp_data_q  <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      shift_q     <= shift_d;
      tdo_q       <= tdo_d;
      busy_q      <= busy_d;
      sticky_q    <= sticky_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
      rsp_data_q  <= rsp_data_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign jtag_TDO      = tdo_q;
  assign dtm_req_valid = req_valid_q;
  assign dtm_req_data  = req_data_q;

endmodule

// File: tb/tb_jtag_tap_dtm.sv
// Directed bench for jtag_tap_dtm: drives the probe pins through full IR/DR
// scans and compares scanned-out words and request outputs against hand values.
module tb_jtag_tap_dtm;

  logic        clk = 1'b0;
  logic        rst, tck, tms, tdi, tdo;
  logic        reqValid, ack, respValid;
  logic [39:0] reqData;
  logic [31:0] respData;
  logic [39:0] dout;
  logic        bitOut;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  jtag_tap_dtm dut (
    .clk           (clk),
    .rst           (rst),
    .jtag_TCK      (tck),
    .jtag_TMS      (tms),
    .jtag_TDI      (tdi),
    .jtag_TDO      (tdo),
    .dtm_req_valid (reqValid),
    .dtm_req_data  (reqData),
    .dm_ack        (ack),
    .dm_resp_valid (respValid),
    .dm_resp_data  (respData)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full TCK period; TDO is sampled well after the falling edge has propagated.
  task automatic tckCycle(input logic m, input logic d, output logic o);
    tms = m;
    tdi = d;
    tck = 1'b1;
    waitClk(4);
    tck = 1'b0;
    waitClk(4);
    o = tdo;
  endtask

  task automatic tapReset();
    logic o;
    for (int i = 0; i < 5; i++) tckCycle(1'b1, 1'b0, o);
    tckCycle(1'b0, 1'b0, o);
  endtask

  // Idle -> capture -> shift len bits LSB-first -> update -> idle.
  task automatic applyStimulus(input bit isIr, input int len, input logic [39:0] din,
                               output logic [39:0] dout);
    logic o;
    dout = '0;
    tckCycle(1'b1, 1'b0, o);
    if (isIr) tckCycle(1'b1, 1'b0, o);
    tckCycle(1'b0, 1'b0, o);
    tckCycle(1'b0, 1'b0, o);
    dout[0] = o;
    for (int i = 0; i < len; i++) begin
      tckCycle((i == len - 1), din[i], o);
      if (i < len - 1) dout[i+1] = o;
    end
    tckCycle(1'b1, 1'b0, o);
    tckCycle(1'b0, 1'b0, o);
  endtask

  task automatic pulseResponse(input logic [31:0] data);
    respValid = 1'b1;
    respData  = data;
    waitClk(1);
    respValid = 1'b0;
    respData  = '0;
  endtask

  initial begin
    rst = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
    ack = 1'b0; respValid = 1'b0; respData = '0;
    waitClk(4);
    checkOutput("reset_tdo", 64'(tdo), 64'h0);
    checkOutput("reset_valid", 64'(reqValid), 64'h0);
    checkOutput("reset_data", 64'(reqData), 64'h0);
    rst = 1'b0;
    waitClk(2);

    tapReset();
    applyStimulus(1'b0, 32, 40'h0, dout);
    checkOutput("idcode", 64'(dout[31:0]), 64'h1E200A6D);

    applyStimulus(1'b1, 5, 40'h10, dout);
    checkOutput("ir_capture", 64'(dout[4:0]), 64'h01);
    applyStimulus(1'b0, 32, 40'h0, dout);
    checkOutput("dtmcs_idle", 64'(dout[31:0]), 64'h00005061);

    applyStimulus(1'b1, 5, 40'h1f, dout);
    applyStimulus(1'b0, 4, 40'hB, dout);
    checkOutput("bypass_delay", 64'(dout[3:0]), 64'h6);

    applyStimulus(1'b1, 5, 40'h11, dout);
    applyStimulus(1'b0, 40, 40'h4000000002, dout);
    checkOutput("dmi_cap_initial", 64'(dout), 64'h0);
    checkOutput("write_valid", 64'(reqValid), 64'h1);
    checkOutput("write_data", 64'(reqData), 64'h4000000002);
    waitClk(5);
    checkOutput("write_valid_held", 64'(reqValid), 64'h1);
    ack = 1'b1;
    waitClk(1);
    ack = 1'b0;
    checkOutput("write_valid_after_ack", 64'(reqValid), 64'h0);
    pulseResponse(32'h12345678);
    applyStimulus(1'b0, 40, 40'h0, dout);
    checkOutput("dmi_after_write", 64'(dout), 64'h4048D159E0);

    applyStimulus(1'b0, 40, 40'h4400000001, dout);
    checkOutput("read1_capture", 64'(dout), 64'h4048D159E0);
    checkOutput("read1_data", 64'(reqData), 64'h4400000001);
    ack = 1'b1;
    waitClk(1);
    ack = 1'b0;
    applyStimulus(1'b0, 40, 40'h4400000001, dout);
    checkOutput("read2_busy", 64'(dout), 64'h4448D159E3);
    checkOutput("read2_dropped", 64'(reqValid), 64'h0);
    applyStimulus(1'b0, 40, 40'h0, dout);
    checkOutput("sticky_status", 64'(dout[1:0]), 64'h3);

    applyStimulus(1'b1, 5, 40'h10, dout);
    applyStimulus(1'b0, 32, 40'h00010000, dout);
    checkOutput("dtmcs_busy", 64'(dout[31:0]), 64'h00005C61);
    pulseResponse(32'hDEADBEEF);
    applyStimulus(1'b1, 5, 40'h11, dout);
    applyStimulus(1'b0, 40, 40'h0, dout);
    checkOutput("read_response", 64'(dout), 64'h477AB6FBBC);
    checkOutput("read_rdata", 64'(dout[33:2]), 64'hDEADBEEF);

    applyStimulus(1'b0, 40, 40'h1696969696, dout);
    checkOutput("write2_valid", 64'(reqValid), 64'h1);
    checkOutput("write2_data", 64'(reqData), 64'h1696969696);

    // Park mid Shift-DR with a request pending, then hit reset.
    tckCycle(1'b1, 1'b0, bitOut);
    tckCycle(1'b0, 1'b0, bitOut);
    tckCycle(1'b0, 1'b0, bitOut);
    checkOutput("shift_tdo_busy", 64'(bitOut), 64'h1);
    tckCycle(1'b0, 1'b0, bitOut);
    rst = 1'b1;
    waitClk(1);
    checkOutput("rst_valid", 64'(reqValid), 64'h0);
    checkOutput("rst_tdo", 64'(tdo), 64'h0);
    checkOutput("rst_data", 64'(reqData), 64'h0);
    rst = 1'b0;
    waitClk(2);
    tckCycle(1'b0, 1'b0, bitOut);
    applyStimulus(1'b0, 32, 40'h0, dout);
    checkOutput("rst_ir_idcode", 64'(dout[31:0]), 64'h1E200A6D);
    applyStimulus(1'b1, 5, 40'h11, dout);
    applyStimulus(1'b0, 40, 40'h0, dout);
    checkOutput("rst_dmi_clear", 64'(dout), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
